data_mem_responder: RTL

Responder end of the core–cache request/response bus. It sits opposite the pipeline's memory stage on the data-side port. It accepts one READ or WRITE request at a time and services it from a local word-addressed data array. After a configurable latency it returns a response and holds it until the core acknowledges it. It is the single-outstanding backing store used for the data path in simulation and in small builds.

---
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Single-outstanding responder for the data-side request/response bus.
//   Accepts one READ or WRITE at a time, services it from a local
//   word-addressed 64-bit array, and returns a response LATENCY+1 cycles
//   after the (data) reqack. The response is held until respack.
//
// Ports
//   clk      - bus clock
//   reset    - synchronous, active-high
//   reqcyc   - request valid (held until reqack)
//   req      - address beat, or write-data beat for WRITE
//   reqtag   - {type(1=WRITE), target, source, id[6:0]}
//   reqack   - one-cycle pulse: current beat taken
//   respcyc  - response valid, held until respack
//   resp     - read data (0 for WRITE completions)
//   resptag  - echoed reqtag of the answered request
//   respack  - response acknowledge, level-sampled
module data_mem_responder #(
  parameter int WORDS   = 512,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqcyc,
  input  logic [63:0] req,
  input  logic [12:0] reqtag,
  output logic        reqack,
  output logic        respcyc,
  output logic [63:0] resp,
  output logic [12:0] resptag,
  input  logic        respack
);

  localparam int IW = $clog2(WORDS);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [12:0]     tag_q, tag_d;
  logic [63:0]     data_q, data_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            reqack_q, reqack_d;
  logic            respcyc_q, respcyc_d;
  logic [63:0]     resp_q, resp_d;
  logic [12:0]     resptag_q, resptag_d;
  logic            mem_we;
  logic [IW-1:0]   req_idx;

  // Not reset: contents survive reset by design.
  logic [63:0]     mem [WORDS];

  // Byte address -> word index; bits above the array size wrap.
  assign req_idx = req[3 +: IW];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tag_d     = tag_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    reqack_d  = 1'b0;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqcyc) begin
          idx_d    = req_idx;
          tag_d    = reqtag;
          reqack_d = 1'b1;
          if (reqtag[12]) begin
            state_d = WDATA;
          end else begin
            data_d  = mem[req_idx];
            cnt_d   = LAT4;
            state_d = WAIT;
          end
        end
      end
      WDATA: begin
        // reqcyc is still asserted for the address beat while its reqack
        // is out; only a beat seen with reqack low is the data beat.
        if (!reqack_q && reqcyc) begin
          mem_we   = 1'b1;
          reqack_d = 1'b1;
          data_d   = '0;
          cnt_d    = LAT4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = RESP;
          respcyc_d = 1'b1;
          resp_d    = data_q;
          resptag_d = tag_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (respack) begin
          state_d   = IDLE;
          respcyc_d = 1'b0;
          resp_d    = '0;
          resptag_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      tag_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  // Reset at the data-beat edge suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx_q] <= req;
  end

  assign reqack  = reqack_q;
  assign respcyc = respcyc_q;
  assign resp    = resp_q;
  assign resptag = resptag_q;

endmodule
